// File: rtl/aes_core_sequencer_if.sv
// Handshake and core-side signal bundle for aes_core_sequencer.
// The slave modport is the sequencer; the master drives blocks in and models the core.
interface aes_core_sequencer_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_key;
   logic [127:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         core_reset;
   logic [7:0]   core_key;
   logic [7:0]   core_state;
   logic [127:0] core_text;

   modport slave (
      input  in_valid, in_key, in_state, out_ready, core_text,
      output in_ready, out_valid, out_data, core_reset, core_key, core_state
   );

   modport master (
      output in_valid, in_key, in_state, out_ready, core_text,
      input  in_ready, out_valid, out_data, core_reset, core_key, core_state
   );
endinterface

// File: rtl/aes_core_sequencer.sv
// Front-end sequencer for the byte-serial AES core: accepts a key/plaintext block, streams
// 16 byte pairs MSB-first, waits out the core latency and returns the captured result.
module aes_core_sequencer #(
   parameter int unsigned CORE_LATENCY = 12,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                clk,
   input  logic                reset,
   aes_core_sequencer_if.slave bus,
   output logic                busy,
   output logic [CNT_W-1:0]    block_count
);

   typedef enum logic [1:0] {StIdle, StLoad, StWait, StDone} state_e;

   localparam logic [7:0] WaitLast = 8'(CORE_LATENCY - 1);

   state_e       r_state;
   state_e       w_state_next;
   logic [3:0]   r_idx;
   logic [3:0]   w_idx_inc;
   logic [6:0]   w_byte_base;
   logic [7:0]   r_wait;
   logic         w_wait_last;
   logic [127:0] r_key;
   logic [127:0] r_st;
   logic [127:0] r_out_data;
   logic [7:0]   r_core_key;
   logic [7:0]   r_core_state;
   logic [CNT_W-1:0] r_count;

   assign w_idx_inc   = r_idx + 4'd1;
   // Byte k lives at [127-8k -: 8], i.e. base 8*(15-k); ~k equals 15-k for 4 bits.
   assign w_byte_base = {~w_idx_inc, 3'b000};
   assign w_wait_last = (r_wait == WaitLast);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (bus.in_valid)      w_state_next = StLoad;
         StLoad:  if (r_idx == 4'd15)    w_state_next = StWait;
         StWait:  if (w_wait_last)       w_state_next = StDone;
         StDone:  if (bus.out_ready)     w_state_next = StIdle;
         default:                        w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_idx        <= '0;
         r_wait       <= '0;
         r_key        <= '0;
         r_st         <= '0;
         r_out_data   <= '0;
         r_core_key   <= '0;
         r_core_state <= '0;
         r_count      <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               // Byte 0 is registered on the accept edge so it is on the core in LOAD cycle 1.
               if (bus.in_valid) begin
                  r_key        <= bus.in_key;
                  r_st         <= bus.in_state;
                  r_idx        <= '0;
                  r_core_key   <= bus.in_key[127:120];
                  r_core_state <= bus.in_state[127:120];
               end
            end
            StLoad: begin
               if (r_idx == 4'd15) begin
                  r_wait <= '0;
               end else begin
                  r_idx        <= w_idx_inc;
                  r_core_key   <= r_key[w_byte_base +: 8];
                  r_core_state <= r_st[w_byte_base +: 8];
               end
            end
            StWait: begin
               if (w_wait_last) begin
                  r_out_data <= bus.core_text;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            StDone: begin
               if (bus.out_ready && (r_count != {CNT_W{1'b1}})) begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = (r_state == StIdle) & reset;
   assign bus.out_valid  = (r_state == StDone);
   assign bus.out_data   = r_out_data;
   assign bus.core_reset = (r_state == StIdle) | ~reset;
   assign bus.core_key   = r_core_key;
   assign bus.core_state = r_core_state;
   assign busy           = (r_state != StIdle);
   assign block_count    = r_count;

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Directed bench for aes_core_sequencer with a mock core that only yields the known
// ciphertext when the full byte stream arrived intact and is sampled on the right cycle.
module tb_aes_core_sequencer;
   localparam int unsigned LAT = 12;
   localparam int unsigned CNT = 2;
   localparam logic [127:0] K  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
   localparam logic [127:0] P  = 128'h3243F6A8885A308D313198A2E0370734;
   localparam logic [127:0] CT = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam logic [127:0] AK = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
   localparam logic [127:0] AP = 128'h5F5E5D5C5B5A59585756555453525150;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           busy;
   logic [CNT-1:0] block_count;
   int             n_checks = 0;
   int             n_fail = 0;
   int             cyc = 0;
   int             acc_q[$];
   int             n_acc;
   int             base;
   int             saw_valid;

   aes_core_sequencer_if bus();

   aes_core_sequencer #(.CORE_LATENCY(LAT), .CNT_W(CNT)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .busy        (busy),
      .block_count (block_count)
   );

   always #5 clk = ~clk;

   // Mock core: collects the streamed bytes, presents its result only on the last WAIT cycle.
   int           m_cyc = 0;
   logic [127:0] m_key = '0;
   logic [127:0] m_st  = '0;

   function automatic logic [127:0] mock_ct(input logic [127:0] k, input logic [127:0] s);
      return (k == K && s == P) ? CT : (k ^ s);
   endfunction

   always @(posedge clk) begin
      if (bus.core_reset) begin
         m_cyc <= 0;
      end else begin
         if (m_cyc < 16) begin
            m_key <= {m_key[119:0], bus.core_key};
            m_st  <= {m_st[119:0], bus.core_state};
         end
         m_cyc <= m_cyc + 1;
      end
   end

   assign bus.core_text = (m_cyc == 15 + LAT) ? mock_ct(m_key, m_st) : 128'hDEADBEEF_0BAD_F00D_5555_AAAA_C0FFEE00;

   always @(posedge clk) begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      cyc <= cyc + 1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_key    = '0;
      bus.in_state  = '0;
      bus.out_ready = 1'b1;

      // Reset with random inputs
      reset = 1'b0;
      repeat (3) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
         bus.in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick(1);
      end
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_core_reset", bus.core_reset, 1);
      chk("rst_count", block_count, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_core_key", bus.core_key, 0);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      tick(1);
      chk("rel_in_ready", bus.in_ready, 1);

      // FIPS-197 vector
      bus.in_valid = 1'b1;
      bus.in_key   = K;
      bus.in_state = P;
      chk("fips_accept_ready", bus.in_ready, 1);
      tick(1);
      bus.in_valid = 1'b0;
      chk("fips_b0_key", bus.core_key, 8'h2B);
      chk("fips_b0_state", bus.core_state, 8'h32);
      chk("fips_busy", busy, 1);
      chk("fips_core_reset", bus.core_reset, 0);
      tick(15);
      chk("fips_b15_key", bus.core_key, 8'h3C);
      chk("fips_b15_state", bus.core_state, 8'h34);
      tick(12);
      chk("fips_c28_valid", bus.out_valid, 0);
      tick(1);
      chk("fips_c29_valid", bus.out_valid, 1);
      chk("fips_c29_data", bus.out_data, CT);
      tick(1);
      chk("fips_post_valid", bus.out_valid, 0);
      chk("fips_count", block_count, 1);
      chk("fips_post_core_reset", bus.core_reset, 1);

      // Input isolation: inputs go all-ones during LOAD byte 5
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      tick(5);
      bus.in_key   = '1;
      bus.in_state = '1;
      chk("iso_b5_key", bus.core_key, 8'hAE);
      chk("iso_b5_state", bus.core_state, 8'h5A);
      tick(1);
      chk("iso_b6_key", bus.core_key, 8'hD2);
      chk("iso_b6_state", bus.core_state, 8'h30);
      tick(9);
      chk("iso_b15_key", bus.core_key, 8'h3C);
      tick(13);
      chk("iso_valid", bus.out_valid, 1);
      chk("iso_data", bus.out_data, CT);
      tick(1);
      chk("iso_count", block_count, 2);

      // Backpressure
      bus.in_key    = K;
      bus.in_state  = P;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      tick(1);
      bus.in_valid = 1'b0;
      tick(28);
      chk("bp_first_valid", bus.out_valid, 1);
      bus.in_valid = 1'b1;
      bus.in_key   = AK;
      bus.in_state = AP;
      n_acc = acc_q.size();
      for (int i = 0; i < 6; i++) begin
         chk("bp_hold_valid", bus.out_valid, 1);
         chk("bp_hold_data", bus.out_data, CT);
         chk("bp_hold_in_ready", bus.in_ready, 0);
         tick(1);
      end
      bus.out_ready = 1'b1;
      chk("bp_release_valid", bus.out_valid, 1);
      tick(1);
      chk("bp_idle_valid", bus.out_valid, 0);
      chk("bp_idle_in_ready", bus.in_ready, 1);
      chk("bp_count", block_count, 3);
      chk("bp_no_early_accept", 128'(acc_q.size() - n_acc), 0);
      tick(1);
      bus.in_valid = 1'b0;
      chk("bp_new_accepted", 128'(acc_q.size() - n_acc), 1);
      chk("bp_new_b0_key", bus.core_key, 8'hA0);
      chk("bp_new_b0_state", bus.core_state, 8'h5F);
      tick(28);
      chk("bp_new_valid", bus.out_valid, 1);
      chk("bp_new_data", bus.out_data, AK ^ AP);
      tick(1);
      chk("bp_count_sat", block_count, 3);

      // Abort at LOAD byte 7
      bus.in_valid = 1'b1;
      tick(1);
      bus.in_valid = 1'b0;
      tick(7);
      chk("abort_b7_key", bus.core_key, 8'hA7);
      chk("abort_b7_state", bus.core_state, 8'h58);
      reset = 1'b0;
      tick(1);
      chk("abort_core_key", bus.core_key, 0);
      chk("abort_core_state", bus.core_state, 0);
      chk("abort_core_reset", bus.core_reset, 1);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", bus.in_ready, 0);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_count", block_count, 0);
      chk("abort_out_data", bus.out_data, 0);
      reset = 1'b1;
      saw_valid = 0;
      repeat (40) begin
         tick(1);
         if (bus.out_valid === 1'b1) saw_valid = 1;
      end
      chk("abort_no_output", 128'(saw_valid), 0);
      chk("abort_count_hold", block_count, 0);

      // Back-to-back, four blocks, counter saturates at 3
      bus.in_key    = K;
      bus.in_state  = P;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      base = acc_q.size();
      tick(90);
      chk("b2b_count3", block_count, 3);
      tick(1);
      bus.in_valid = 1'b0;
      tick(29);
      chk("b2b_idle", busy, 0);
      chk("b2b_count_sat", block_count, 3);
      chk("b2b_accepts", 128'(acc_q.size() - base), 4);
      if (acc_q.size() - base == 4) begin
         for (int i = 1; i < 4; i++) begin
            chk("b2b_gap", 128'(acc_q[base + i] - acc_q[base + i - 1]), 30);
         end
      end
      chk("b2b_data", bus.out_data, CT);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/aes_core_sequencer.md
Name: aes_core_sequencer

Overview:
- Front-end controller for the byte-serial AES_core.
- Accepts a 128-bit key and a 128-bit plaintext block over a valid/ready handshake, holds the core in reset between blocks, and streams 16 key/state byte pairs MSB-first on consecutive cycles.
- After a fixed core latency, captures the 128-bit result and returns it over a valid/ready output handshake.
- Sits between the system bus adapter and AES_core; it is the only driver of the core's inputs.

Parameters:
- CORE_LATENCY, 12: cycles from the last byte presented to the core until core_text is valid; legal range 1..255.
- CNT_W, 16: width of the completed-block counter.

Ports:
- clk  in  1  clock, all logic on the rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  1  input block available
- in_ready  out  1  sequencer can accept a block
- in_key  in  128  cipher key, byte 0 = [127:120]
- in_state  in  128  plaintext, byte 0 = [127:120]
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  128  ciphertext
- core_reset  out  1  to AES_core reset, active-high
- core_key  out  8  to AES_core key byte
- core_state  out  8  to AES_core state byte
- core_text  in  128  from AES_core text
- busy  out  1  state != IDLE
- block_count  out  CNT_W  completed blocks, saturating

Behaviour:
- Reset (reset==0 at a rising edge):
  - FSM goes to IDLE.
  - Byte index, wait counter, key/state capture registers, out_data, block_count and core_key/core_state all clear to 0.
  - out_valid=0.
  - core_reset=1.
  - in_ready=0 while reset is low; in_ready = (FSM==IDLE) & reset.
- Reset mid-operation aborts the block with no output and no count increment.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - core_reset=1, in_ready=1.
  - On in_valid&in_ready, capture in_key/in_state into internal registers, clear the byte index, and go to LOAD.
  - Inputs are ignored in every other state, and input changes after acceptance have no effect.
- LOAD:
  - core_reset=0.
  - Cycle 0 is the handshake cycle. In cycles 1..16, byte k (k=0..15) drives core_key=key_reg[127-8k -:8] and core_state=state_reg[127-8k -:8] during cycle k+1.
  - core_key and core_state are registered outputs.
  - After byte 15, go to WAIT with the wait counter at 0.
- WAIT:
  - core_reset=0; core_key and core_state hold byte 15.
  - The counter runs for CORE_LATENCY cycles (cycles 17..16+CORE_LATENCY).
  - On the edge ending the last WAIT cycle, out_data<=core_text and go to DONE.
- DONE:
  - out_valid=1 from cycle 17+CORE_LATENCY.
  - out_data is stable while out_valid=1.
  - On out_valid&out_ready: block_count increments (holds at all-ones), FSM returns to IDLE, out_valid=0 next cycle, core_reset=1.
  - The next block can be accepted in the cycle after the output handshake (one IDLE cycle between blocks, minimum). This guarantees the core sees at least one reset cycle.
- Throughput: one block per 18+CORE_LATENCY cycles with no backpressure.
- Simultaneous in_valid during DONE is ignored (in_ready=0). It is accepted only once IDLE is reached.
- out_ready is don't-care outside DONE.
- core_text is sampled only at the WAIT→DONE edge.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs → in_ready=0, out_valid=0, busy=0, core_reset=1, block_count=0, out_data=0. Release → in_ready=1 next cycle.
- FIPS-197 App. B vector: in_key=2B7E151628AED2A6ABF7158809CF4F3C, in_state=3243F6A8885A308D313198A2E0370734, out_ready=1.
  - Cycle 1: core_key=2B, core_state=32.
  - Cycle 16: core_key=3C, core_state=34.
  - Cycle 29 (CORE_LATENCY=12): out_valid=1, out_data=3925841D02DC09FBDC118597196A0B32.
  - block_count=1.
- Backpressure: same vector with out_ready=0 for 6 cycles after out_valid → out_valid and out_data are stable; in_valid=1 with a new block is not accepted (in_ready=0). Raise out_ready → handshake, IDLE, then the new block is accepted one cycle later.
- Input isolation: change in_key/in_state to all-FF during LOAD byte 5 → byte stream and result match the original vector.
- Abort: reset=0 at LOAD byte 7 → next cycle all outputs are at reset values. No out_valid appears, and block_count stays 0.
- Back-to-back: in_valid held high and out_ready=1 for 3 blocks → accept edges are 30 cycles apart (CORE_LATENCY=12), block_count=3. With CNT_W=2, a 4th block leaves block_count=3 (saturated).
